wb_slave_mux: RTL and testbench
===============================

# wb_slave_mux

Parametrised Wishbone classic slave-side fabric for the user project wrapper. It fans one management-SoC Wishbone port out to `NUM_SLAVES` user peripherals, such as AES cores, by address window. It guards each transfer with a timeout, and exposes a small CSR window with timeout status and an interrupt mask. The masked peripheral interrupts drive `user_irq`. It sits directly under the wrapper, between the `wbs_*` pins and the peripheral instances.

## Interface
- `NUM_SLAVES`, 4, number of downstream peripherals (1..15)
- `BASE_ADDR`, 32'h3000_0000, base of the user address space
- `SLAVE_SHIFT`, 16, log2 of the window size; the default gives 64 KiB per window
- `TIMEOUT`, 255, cycles to wait for a downstream ack before an error response (1..65535)
- `wb_clk_i` in 1: the only clock
- `wb_rst_n_i` in 1: reset; synchronous, active-low
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i` in 1: host bus cycle, strobe and write enable
- `wbs_sel_i` in 4: host byte selects
- `wbs_adr_i`, `wbs_dat_i` in 32: host address and write data
- `wbs_ack_o` out 1: single-cycle ack
- `wbs_dat_o` out 32: read data, valid only with `wbs_ack_o`
- `m_cyc_o`, `m_stb_o` out NUM_SLAVES: per-peripheral cycle and strobe, one-hot
- `m_we_o` out 1, `m_sel_o` out 4, `m_adr_o` out 32, `m_dat_o` out 32: shared request fields, registered
- `m_dat_i` in NUM_SLAVES*32: peripheral read data; slave k occupies bits [32k+31:32k]
- `m_ack_i` in NUM_SLAVES: peripheral acks
- `irq_i` in NUM_SLAVES: level interrupts from the peripherals
- `user_irq` out 3: registered interrupt outputs

## Operation
- **Address decode**
  - `IDXW` = clog2(NUM_SLAVES+1).
  - `idx` = `wbs_adr_i[SLAVE_SHIFT+IDXW-1:SLAVE_SHIFT]`.
  - A hit requires `wbs_adr_i[31:SLAVE_SHIFT+IDXW]` to equal the same bits of `BASE_ADDR`.
  - `idx < NUM_SLAVES` selects a peripheral.
  - `idx == NUM_SLAVES` selects the CSR window.
  - Anything else is out of range.
- **FSM states**: IDLE, FWD, RESP.
  - IDLE, with `cyc&stb` and no ack pending:
    - Latch `we`, `sel`, `adr` and `dat`.
    - Peripheral hit: go to FWD and assert `m_cyc_o[idx]`/`m_stb_o[idx]` from the next cycle.
    - CSR hit or out of range: go to RESP.
  - FWD:
    - Hold the strobe until `m_ack_i[idx]`, then go to RESP with the data latched from slice `idx`; the strobe drops in the same edge.
    - The timeout counter counts up while in FWD. When it reaches `TIMEOUT`, drop the strobe, set sticky bit `STATUS[idx]`, load the data with 32'hDEAD_0000|idx, and go to RESP.
  - RESP: `wbs_ack_o`=1 for exactly one cycle, then go to IDLE. Ack is never back-to-back; IDLE needs one cycle before the next accept.
- **Out of range**: writes are dropped; reads return 32'hBADA_DD00.
- **Abort**: if `wbs_cyc_i` falls while in FWD:
  - Clear `m_cyc_o`/`m_stb_o` on the next edge and go to IDLE.
  - Give no host ack and set no status bit.
  - Acks from a peripheral that arrive in IDLE are ignored.
- **CSR window** (offset = `adr[3:2]`). Writes honour `sel` per byte; all other offsets read 0.
  - 0x0 STATUS: `[NUM_SLAVES-1:0]` timeout sticky bits, write-1-to-clear. If a set and a clear hit the same bit in the same cycle, the set wins.
  - 0x4 IRQ_MASK: read/write, reset value 0.
  - 0x8 IRQ_PEND: read-only, `irq_i & IRQ_MASK`.
  - 0xC ID: read-only, {16'h5753, 8'(NUM_SLAVES), 8'h01}.
- **Interrupts**
  - `user_irq[0]` = |(`irq_i` & mask), registered.
  - `user_irq[1]` = |STATUS.
  - `user_irq[2]` = 0 (reserved).
- **Reset**
  - FSM goes to IDLE.
  - All outputs are 0, including `wbs_dat_o`, `m_*` and `user_irq`.
  - STATUS, IRQ_MASK and the timeout counter are cleared.
  - Reset during FWD drops the strobe on that edge; no ack is produced.

## Timing
- Cycle 0: host request sampled.
- Cycle 1: downstream strobe high.
- If the peripheral acks in cycle n (n ≥ 1), `wbs_ack_o` is high in cycle n+1.
- Minimum peripheral latency is 2 cycles from host strobe to ack. CSR and out-of-range accesses ack at cycle 1.
- A timeout ack arrives at cycle TIMEOUT+2.
- `wbs_dat_o` is zero in every cycle without ack.
- Interrupt path: `user_irq` lags `irq_i` by 1 cycle.

## Structure
- **Package `wb_mux_pkg`**: FSM state enum, CSR offset constants, ID constant, error data constants 32'hDEAD_0000 and 32'hBADA_DD00.
- **Sub-module `wb_mux_csr`**: STATUS/IRQ_MASK registers, read mux and interrupt outputs. The FSM, decode and timeout stay in `wb_slave_mux`.

## Test plan
- **Peripheral read**: read 0x3001_0004 with slave 1 acking 1 cycle after its strobe and data 32'hCAFE_F00D -> `m_stb_o`=4'b0010 for 2 cycles; `wbs_ack_o` at cycle 3 with 32'hCAFE_F00D.
- **Timeout**: write to 0x3002_0000 with slave 2 never acking and TIMEOUT=8 -> ack at cycle 10 with 32'hDEAD_0002; STATUS reads 4'b0100; `user_irq[1]`=1. Writing 4'b0100 to STATUS clears it and `user_irq[1]` falls.
- **CSR and ID**: read 0x3004_000C -> 32'h5753_0401 acked at cycle 1. Write IRQ_MASK=4'b1000, raise `irq_i[3]` -> `user_irq[0]` one cycle later. Raise only `irq_i[0]` -> `user_irq` stays 0.
- **Out of range and byte select**: read 0x3006_0000 -> 32'hBADA_DD00. Write 0x3100_0000 -> acked, no `m_stb_o`. A CSR write with `sel`=4'b0001 changes only IRQ_MASK[7:0].
- **Abort, reset, collision**:
  - Drop `wbs_cyc_i` in FWD -> strobe clears next cycle; a late `m_ack_i` causes no host ack.
  - Assert `wb_rst_n_i`=0 mid-FWD -> all outputs 0 on the next edge.
  - Timeout set and W1C on the same bit in one cycle -> bit stays set.

Source files
------------

// File: rtl/wb_mux_pkg.sv
// rtl/wb_mux_pkg.sv - shared types and constants for the Wishbone slave fan-out
package wb_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [1:0] CSR_STATUS   = 2'd0;
  localparam logic [1:0] CSR_IRQ_MASK = 2'd1;
  localparam logic [1:0] CSR_IRQ_PEND = 2'd2;
  localparam logic [1:0] CSR_ID       = 2'd3;

  localparam logic [15:0] ID_MAGIC = 16'h5753;
  localparam logic [7:0]  ID_REV   = 8'h01;

  localparam logic [31:0] ERR_TIMEOUT = 32'hDEAD_0000;
  localparam logic [31:0] ERR_RANGE   = 32'hBADA_DD00;

  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/wb_mux_csr.sv
// rtl/wb_mux_csr.sv - timeout status, interrupt mask, CSR read mux and user_irq
module wb_mux_csr
  import wb_mux_pkg::*;
#(
  parameter int NUM_SLAVES = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [NUM_SLAVES-1:0] irq_i,
  input  logic [NUM_SLAVES-1:0] to_set_i,
  input  logic                  wr_en_i,
  input  logic [1:0]            offset_i,
  input  logic [3:0]            sel_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o,
  output logic [2:0]            user_irq_o
);

  logic [NUM_SLAVES-1:0] status_q, status_d;
  logic [31:0]           mask_q, mask_d;
  logic [2:0]            irq_q, irq_d;
  logic [31:0]           wmask;
  logic [NUM_SLAVES-1:0] pend;

  assign pend = irq_i & mask_q[NUM_SLAVES-1:0];

  always_comb begin
    wmask    = byte_mask(sel_i);
    status_d = status_q;
    mask_d   = mask_q;
    if (wr_en_i && offset_i == CSR_STATUS) begin
      for (int k = 0; k < NUM_SLAVES; k++) begin
        if (sel_i[k/8] && wdata_i[k]) status_d[k] = 1'b0;
      end
    end
    if (wr_en_i && offset_i == CSR_IRQ_MASK) begin
      mask_d = (mask_q & ~wmask) | (wdata_i & wmask);
    end
    // A timeout landing on a bit being cleared keeps it set.
    status_d = status_d | to_set_i;
    irq_d    = {1'b0, |status_d, |pend};
  end

  always_comb begin
    rdata_o = '0;
    case (offset_i)
      CSR_STATUS:   rdata_o = 32'(status_q);
      CSR_IRQ_MASK: rdata_o = mask_q;
      CSR_IRQ_PEND: rdata_o = 32'(pend);
      CSR_ID:       rdata_o = {ID_MAGIC, 8'(NUM_SLAVES), ID_REV};
      default:      rdata_o = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      status_q <= '0;
      mask_q   <= '0;
      irq_q    <= '0;
    end else begin
      status_q <= status_d;
      mask_q   <= mask_d;
      irq_q    <= irq_d;
    end
  end

  assign user_irq_o = irq_q;

endmodule

// File: rtl/wb_slave_mux.sv
// rtl/wb_slave_mux.sv - Wishbone classic fan-out to NUM_SLAVES peripherals
// with address-window decode, per-transfer timeout and a CSR window.
module wb_slave_mux
  import wb_mux_pkg::*;
#(
  parameter int          NUM_SLAVES  = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          SLAVE_SHIFT = 16,
  parameter int          TIMEOUT     = 255
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_n_i,
  input  logic                     wbs_cyc_i,
  input  logic                     wbs_stb_i,
  input  logic                     wbs_we_i,
  input  logic [3:0]               wbs_sel_i,
  input  logic [31:0]              wbs_adr_i,
  input  logic [31:0]              wbs_dat_i,
  output logic                     wbs_ack_o,
  output logic [31:0]              wbs_dat_o,
  output logic [NUM_SLAVES-1:0]    m_cyc_o,
  output logic [NUM_SLAVES-1:0]    m_stb_o,
  output logic                     m_we_o,
  output logic [3:0]               m_sel_o,
  output logic [31:0]              m_adr_o,
  output logic [31:0]              m_dat_o,
  input  logic [NUM_SLAVES*32-1:0] m_dat_i,
  input  logic [NUM_SLAVES-1:0]    m_ack_i,
  input  logic [NUM_SLAVES-1:0]    irq_i,
  output logic [2:0]               user_irq
);

  localparam int          IDXW = $clog2(NUM_SLAVES + 1);
  localparam int          TOPB = SLAVE_SHIFT + IDXW;
  localparam logic [15:0] TMO  = 16'(TIMEOUT);

  state_e          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            we_q, we_d;
  logic [3:0]      sel_q, sel_d;
  logic [31:0]     adr_q, adr_d;
  logic [31:0]     wdat_q, wdat_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [15:0]     cnt_q, cnt_d;

  logic [IDXW-1:0]       req_idx;
  logic                  req_hit, req_periph, req_csr;
  logic [NUM_SLAVES-1:0] sel_oh, to_set;
  logic                  ack_sel;
  logic [31:0]           dat_sel;
  logic                  csr_wr;
  logic [31:0]           csr_rdata;

  assign req_idx    = wbs_adr_i[SLAVE_SHIFT +: IDXW];
  assign req_hit    = (wbs_adr_i[31:TOPB] == BASE_ADDR[31:TOPB]);
  assign req_periph = req_hit && (int'(req_idx) < NUM_SLAVES);
  assign req_csr    = req_hit && (int'(req_idx) == NUM_SLAVES);

  // Steer ack and read data from the peripheral owning the current transfer.
  always_comb begin
    sel_oh  = '0;
    ack_sel = 1'b0;
    dat_sel = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      sel_oh[k] = (int'(idx_q) == k);
      if (sel_oh[k]) begin
        ack_sel = m_ack_i[k];
        dat_sel = m_dat_i[32*k +: 32];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    to_set  = '0;
    csr_wr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          idx_d  = req_idx;
          we_d   = wbs_we_i;
          sel_d  = wbs_sel_i;
          adr_d  = wbs_adr_i;
          wdat_d = wbs_dat_i;
          cnt_d  = '0;
          if (req_periph) begin
            state_d = ST_FWD;
          end else begin
            state_d = ST_RESP;
            if (req_csr) begin
              rdata_d = csr_rdata;
              csr_wr  = wbs_we_i;
            end else begin
              rdata_d = ERR_RANGE;
            end
          end
        end
      end
      ST_FWD: begin
        // A host abort wins over a same-cycle ack or timeout.
        if (!wbs_cyc_i) begin
          state_d = ST_IDLE;
        end else if (ack_sel) begin
          state_d = ST_RESP;
          rdata_d = dat_sel;
        end else if (cnt_q == TMO) begin
          state_d = ST_RESP;
          rdata_d = ERR_TIMEOUT | 32'(idx_q);
          to_set  = sel_oh;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      wdat_q  <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  wb_mux_csr #(
    .NUM_SLAVES(NUM_SLAVES)
  ) u_csr (
    .clk_i      (wb_clk_i),
    .rst_n_i    (wb_rst_n_i),
    .irq_i      (irq_i),
    .to_set_i   (to_set),
    .wr_en_i    (csr_wr),
    .offset_i   (wbs_adr_i[3:2]),
    .sel_i      (wbs_sel_i),
    .wdata_i    (wbs_dat_i),
    .rdata_o    (csr_rdata),
    .user_irq_o (user_irq)
  );

  assign wbs_ack_o = (state_q == ST_RESP);
  assign wbs_dat_o = wbs_ack_o ? rdata_q : '0;
  assign m_cyc_o   = (state_q == ST_FWD) ? sel_oh : '0;
  assign m_stb_o   = m_cyc_o;
  assign m_we_o    = we_q;
  assign m_sel_o   = sel_q;
  assign m_adr_o   = adr_q;
  assign m_dat_o   = wdat_q;

endmodule

// File: tb/tb_wb_slave_mux.sv
// tb/tb_wb_slave_mux.sv - directed bench with a cycle-timeline model of the fabric
module tb_wb_slave_mux;
  import wb_mux_pkg::*;

  localparam int          NS   = 4;
  localparam int          TMO  = 8;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int          NCYC = 4096;
  localparam int          IDXW = $clog2(NS + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
  logic [3:0]    sel_i = '0;
  logic [31:0]   adr_i = '0, dat_i = '0;
  logic          ack_o;
  logic [31:0]   dat_o;
  logic [NS-1:0] m_cyc, m_stb;
  logic          m_we;
  logic [3:0]    m_sel;
  logic [31:0]   m_adr, m_dat;
  logic [NS*32-1:0] m_dat_in;
  logic [NS-1:0] m_ack = '0, irq = '0;
  logic [2:0]    uirq;

  logic [NS-1:0] iso_set = '0;
  logic          iso_wr = 1'b0;
  logic [1:0]    iso_off = '0;
  logic [3:0]    iso_sel = '0;
  logic [31:0]   iso_wdata = '0;
  logic [31:0]   iso_rdata;
  logic [2:0]    iso_irq;

  wb_slave_mux #(
    .NUM_SLAVES(NS), .BASE_ADDR(BASE), .SLAVE_SHIFT(16), .TIMEOUT(TMO)
  ) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .wbs_cyc_i(cyc_i), .wbs_stb_i(stb_i), .wbs_we_i(we_i), .wbs_sel_i(sel_i),
    .wbs_adr_i(adr_i), .wbs_dat_i(dat_i), .wbs_ack_o(ack_o), .wbs_dat_o(dat_o),
    .m_cyc_o(m_cyc), .m_stb_o(m_stb), .m_we_o(m_we), .m_sel_o(m_sel),
    .m_adr_o(m_adr), .m_dat_o(m_dat), .m_dat_i(m_dat_in), .m_ack_i(m_ack),
    .irq_i(irq), .user_irq(uirq)
  );

  wb_mux_csr #(.NUM_SLAVES(NS)) u_csr_iso (
    .clk_i(clk), .rst_n_i(rst_n), .irq_i('0), .to_set_i(iso_set),
    .wr_en_i(iso_wr), .offset_i(iso_off), .sel_i(iso_sel), .wdata_i(iso_wdata),
    .rdata_o(iso_rdata), .user_irq_o(iso_irq)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int n_checks = 0;
  int n_fail = 0;

  // Expected host/peripheral timeline, indexed by cycle number.
  logic          exp_ack  [NCYC];
  logic          exp_dchk [NCYC];
  logic [31:0]   exp_dat  [NCYC];
  logic [NS-1:0] exp_stb  [NCYC];
  logic [31:0]   exp_madr [NCYC];

  logic [31:0]   slave_dat [NS];
  logic [NS-1:0] mdl_status = '0;
  logic [31:0]   mdl_mask = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %08h expected %08h", name, cyc_n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cyc_n < NCYC) begin
      chk("wbs_ack", 32'(ack_o), 32'(exp_ack[cyc_n]));
      if (!exp_ack[cyc_n]) chk("wbs_dat_noack", dat_o, 32'h0);
      else if (exp_dchk[cyc_n]) chk("wbs_dat", dat_o, exp_dat[cyc_n]);
      chk("m_stb", 32'(m_stb), 32'(exp_stb[cyc_n]));
      chk("m_cyc", 32'(m_cyc), 32'(exp_stb[cyc_n]));
      if (exp_stb[cyc_n] != '0) chk("m_adr", m_adr, exp_madr[cyc_n]);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // 0..NS-1 peripheral, NS CSR window, -1 out of range.
  function automatic int decode(input logic [31:0] a);
    logic [31:0] off;
    if (a < BASE) return -1;
    off = a - BASE;
    if (off >= (32'd1 << (16 + IDXW))) return -1;
    if ((off >> 16) > NS) return -1;
    return int'(off >> 16);
  endfunction

  function automatic logic [31:0] csr_model(input logic [1:0] off);
    case (off)
      2'd0:    return 32'(mdl_status);
      2'd1:    return mdl_mask;
      2'd2:    return 32'(irq & mdl_mask[NS-1:0]);
      default: return {16'h5753, 8'(NS), 8'h01};
    endcase
  endfunction

  task automatic csr_write(input logic [1:0] off, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++) begin
      if (s[b]) begin
        if (off == 2'd1) mdl_mask[8*b +: 8] = d[8*b +: 8];
        if (off == 2'd0 && b == 0) mdl_status = mdl_status & ~d[NS-1:0];
      end
    end
  endtask

  // lat: cycles from strobe rise to peripheral ack; negative means never ack.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] s, input int lat, output logic [31:0] rd);
    int t0, idx, lt, ta;
    t0 = cyc_n;
    adr_i = a; we_i = w; dat_i = d; sel_i = s; cyc_i = 1'b1; stb_i = 1'b1;
    idx = decode(a);
    if (idx >= 0 && idx < NS) begin
      lt = (lat < 0) ? TMO : lat;
      for (int c = t0 + 1; c <= t0 + 1 + lt; c++) begin
        exp_stb[c]  = NS'(1 << idx);
        exp_madr[c] = a;
      end
      ta = t0 + 2 + lt;
      exp_ack[ta] = 1'b1;
      if (lat < 0) begin
        exp_dchk[ta] = 1'b1;
        exp_dat[ta]  = 32'hDEAD_0000 | 32'(idx);
        mdl_status[idx] = 1'b1;
        step(ta - t0);
      end else begin
        exp_dchk[ta] = !w;
        exp_dat[ta]  = slave_dat[idx];
        step(1 + lat);
        m_ack[idx] = 1'b1;
        step(1);
        m_ack = '0;
      end
    end else begin
      ta = t0 + 1;
      exp_ack[ta]  = 1'b1;
      exp_dchk[ta] = !w;
      if (idx == NS) begin
        exp_dat[ta] = csr_model(a[3:2]);
        if (w) csr_write(a[3:2], d, s);
      end else begin
        exp_dat[ta] = 32'hBADA_DD00;
      end
      step(1);
    end
    rd = dat_o;
    step(1);
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    step(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int t0;
    for (int c = 0; c < NCYC; c++) begin
      exp_ack[c] = 1'b0; exp_dchk[c] = 1'b0; exp_dat[c] = '0;
      exp_stb[c] = '0;   exp_madr[c] = '0;
    end
    slave_dat[0] = 32'h1111_0000;
    slave_dat[1] = 32'hCAFE_F00D;
    slave_dat[2] = 32'h2222_0002;
    slave_dat[3] = 32'h3333_0003;
    for (int k = 0; k < NS; k++) m_dat_in[32*k +: 32] = slave_dat[k];

    step(3);
    chk("reset_user_irq", 32'(uirq), 32'h0);
    rst_n = 1'b1;
    step(1);

    // Peripheral read with 1-cycle peripheral latency.
    xfer(32'h3001_0004, 1'b0, 32'h0, 4'hF, 1, rd);
    chk("periph_read_data", rd, 32'hCAFE_F00D);

    // Timeout on slave 2, then W1C.
    xfer(32'h3002_0000, 1'b1, 32'h0000_1234, 4'hF, -1, rd);
    chk("timeout_data", rd, 32'hDEAD_0002);
    chk("timeout_user_irq1", 32'(uirq[1]), 32'h1);
    xfer(32'h3004_0000, 1'b0, 32'h0, 4'hF, 0, rd);
    chk("status_after_timeout", rd, 32'h0000_0004);
    xfer(32'h3004_0000, 1'b1, 32'h0000_0004, 4'hF, 0, rd);
    chk("w1c_user_irq1", 32'(uirq[1]), 32'h0);
    xfer(32'h3004_0000, 1'b0, 32'h0, 4'hF, 0, rd);
    chk("status_after_w1c", rd, 32'h0);

    // ID and interrupt masking.
    xfer(32'h3004_000C, 1'b0, 32'h0, 4'hF, 0, rd);
    chk("id_read", rd, 32'h5753_0401);
    xfer(32'h3004_0004, 1'b1, 32'h0000_0008, 4'hF, 0, rd);
    irq = 4'b1000;
    chk("irq3_same_cycle", 32'(uirq[0]), 32'h0);
    step(1);
    chk("irq3_next_cycle", 32'(uirq[0]), 32'h1);
    irq = 4'b0001;
    step(2);
    chk("irq0_masked", 32'(uirq), 32'h0);
    xfer(32'h3004_0008, 1'b0, 32'h0, 4'hF, 0, rd);
    chk("irq_pend_masked", rd, 32'h0);

    // Out of range and byte selects.
    xfer(32'h3006_0000, 1'b0, 32'h0, 4'hF, 0, rd);
    chk("oor_read", rd, 32'hBADA_DD00);
    xfer(32'h3100_0000, 1'b1, 32'hFFFF_FFFF, 4'hF, 0, rd);
    xfer(32'h3004_0004, 1'b1, 32'hFFFF_FFFF, 4'b0001, 0, rd);
    xfer(32'h3004_0004, 1'b0, 32'h0, 4'hF, 0, rd);
    chk("mask_byte_sel", rd, 32'h0000_00FF);
    xfer(32'h3004_0008, 1'b0, 32'h0, 4'hF, 0, rd);
    chk("irq_pend_bit0", rd, 32'h0000_0001);

    // Minimum-latency read and a slower write.
    xfer(32'h3003_0010, 1'b0, 32'h0, 4'hF, 0, rd);
    chk("periph3_read", rd, 32'h3333_0003);
    xfer(32'h3000_0020, 1'b1, 32'hA5A5_5A5A, 4'b0011, 3, rd);

    // Abort during FWD with a late peripheral ack.
    t0 = cyc_n;
    adr_i = 32'h3000_0010; we_i = 1'b0; sel_i = 4'hF; cyc_i = 1'b1; stb_i = 1'b1;
    exp_stb[t0 + 1] = 4'b0001; exp_madr[t0 + 1] = 32'h3000_0010;
    exp_stb[t0 + 2] = 4'b0001; exp_madr[t0 + 2] = 32'h3000_0010;
    step(2);
    cyc_i = 1'b0; stb_i = 1'b0;
    step(1);
    m_ack = 4'b0001;
    step(1);
    m_ack = '0;
    step(2);
    xfer(32'h3004_0000, 1'b0, 32'h0, 4'hF, 0, rd);
    chk("status_after_abort", rd, 32'h0);

    // Reset in the middle of a forwarded write.
    t0 = cyc_n;
    adr_i = 32'h3003_0000; we_i = 1'b1; dat_i = 32'h0BAD_F00D; sel_i = 4'hF;
    cyc_i = 1'b1; stb_i = 1'b1;
    exp_stb[t0 + 1] = 4'b1000; exp_madr[t0 + 1] = 32'h3003_0000;
    exp_stb[t0 + 2] = 4'b1000; exp_madr[t0 + 2] = 32'h3003_0000;
    step(2);
    chk("pre_reset_m_we", 32'(m_we), 32'h1);
    chk("pre_reset_user_irq0", 32'(uirq[0]), 32'h1);
    rst_n = 1'b0;
    step(1);
    chk("reset_m_we", 32'(m_we), 32'h0);
    chk("reset_m_adr", m_adr, 32'h0);
    chk("reset_m_dat", m_dat, 32'h0);
    chk("reset_m_sel", 32'(m_sel), 32'h0);
    chk("reset_user_irq_mid", 32'(uirq), 32'h0);
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    mdl_status = '0; mdl_mask = '0;
    step(1);
    rst_n = 1'b1;
    step(1);
    xfer(32'h3004_0004, 1'b0, 32'h0, 4'hF, 0, rd);
    chk("mask_after_reset", rd, 32'h0);

    // Timeout set colliding with W1C on the same STATUS bit.
    iso_set = 4'b0100; iso_wr = 1'b1; iso_off = 2'd0; iso_sel = 4'hF; iso_wdata = 32'h4;
    step(1);
    iso_set = '0; iso_wr = 1'b0;
    chk("collision_keeps_bit", iso_rdata, 32'h0000_0004);
    chk("collision_irq1", 32'(iso_irq[1]), 32'h1);
    iso_wr = 1'b1;
    step(1);
    iso_wr = 1'b0;
    chk("plain_w1c_clears", iso_rdata, 32'h0);

    step(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
